// File: rtl/ip_tx_pkg.sv
`default_nettype none
// ============================================================================
// Module : ip_tx_pkg
// Shared types and constants for the IPv4 transmit framer.
// Rev    : 1.0
// ============================================================================
package ip_tx_pkg;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_CSUM  = 3'd1,
        ST_HDR   = 3'd2,
        ST_PAY   = 3'd3,
        ST_GAP   = 3'd4,
        ST_DRAIN = 3'd5
    } state_t;

    localparam int unsigned C_HDR_LEN   = 20;
    localparam logic [15:0] C_ETHERTYPE = 16'h0800;
    localparam logic [7:0]  C_VER_IHL   = 8'h45;
    localparam logic [15:0] C_FLAGS     = 16'h4000;
    localparam int unsigned C_CSUM_LAT  = 3;

endpackage
`default_nettype wire

// File: rtl/ip_hdr_csum.sv
`default_nettype none
// ============================================================================
// Module : ip_hdr_csum
// 3-cycle pipelined one's-complement checksum over ten 16-bit words.
// Rev    : 1.0
// ============================================================================
module ip_hdr_csum (
    input  logic         i_clk,
    input  logic         i_rst,
    input  logic         i_start,
    input  logic [159:0] i_words,
    output logic [15:0]  o_csum,
    output logic         o_done
);

    logic [19:0] sum_d;
    logic [19:0] sum_q;
    logic [16:0] fold_q;
    logic [15:0] csum_q;
    logic [2:0]  vld_q;

    always_comb begin
        sum_d = '0;
        for (int i = 0; i < 10; i++) begin
            sum_d = sum_d + {4'd0, i_words[16*i +: 16]};
        end
    end

    // Two folds suffice: the first leaves at most a single carry bit.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            sum_q  <= '0;
            fold_q <= '0;
            csum_q <= '0;
            vld_q  <= '0;
        end else begin
            vld_q <= {vld_q[1:0], i_start};
            if (i_start) begin
                sum_q <= sum_d;
            end
            if (vld_q[0]) begin
                fold_q <= {1'b0, sum_q[15:0]} + {13'd0, sum_q[19:16]};
            end
            if (vld_q[1]) begin
                csum_q <= ~(fold_q[15:0] + {15'd0, fold_q[16]});
            end
        end
    end

    assign o_csum = csum_q;
    assign o_done = vld_q[2];

endmodule
`default_nettype wire

// File: rtl/ip_tx.sv
`default_nettype none
// ============================================================================
// Module : ip_tx
// IPv4 transmit framer: prepends a 20-byte header to a UDP payload stream.
// Header checksum generation is enabled by defining IP_TX_CSUM_EN.
// Rev    : 1.0
// ============================================================================
module ip_tx
    import ip_tx_pkg::*;
#(
    parameter logic [31:0] P_SRC_IP      = 32'hC0A8_0001,
    parameter logic [31:0] P_DST_IP      = 32'hC0A8_0002,
    parameter logic [7:0]  P_TTL         = 8'd64,
    parameter logic [7:0]  P_PROTOCOL    = 8'd17,
    parameter logic [15:0] P_MAX_PAYLOAD = 16'd1480,
    parameter logic [3:0]  P_GAP_CYCLES  = 4'd2
) (
    input  logic        i_clk,
    input  logic        i_rst,
    input  logic [31:0] i_src_ip,
    input  logic        i_src_ip_valid,
    input  logic [31:0] i_dst_ip,
    input  logic        i_dst_ip_valid,
    input  logic [15:0] i_send_len,
    input  logic [7:0]  i_send_data,
    input  logic        i_send_last,
    input  logic        i_send_valid,
    output logic        o_send_ready,
    input  logic        i_mac_ready,
    output logic [15:0] o_mac_type,
    output logic [15:0] o_mac_len,
    output logic [7:0]  o_mac_data,
    output logic        o_mac_last,
    output logic        o_mac_valid,
    output logic        o_err_len,
    output logic        o_err_underrun
);

    state_t      state_q;
    logic [3:0]  cnt_q;
    logic [4:0]  hidx_q;
    logic [15:0] pcnt_q;
    logic [15:0] len_q;
    logic [15:0] id_q;
    logic [31:0] src_ip_q;
    logic [31:0] dst_ip_q;
    logic [31:0] src_q;
    logic [31:0] dst_q;
    logic        ended_q;
    logic [7:0]  mac_data_q;
    logic        mac_valid_q;
    logic        mac_last_q;
    logic [15:0] mac_len_q;
    logic        err_len_q;
    logic        err_und_q;

    logic [15:0]  w_tot_len;
    logic [15:0]  w_csum_field;
    logic [159:0] w_hdr;
    logic [7:0]   w_hdr_byte;
    logic         w_len_bad;

    assign w_tot_len  = len_q + 16'(C_HDR_LEN);
    assign w_len_bad  = (i_send_len == 16'd0) || (i_send_len > P_MAX_PAYLOAD);
    assign w_hdr      = {C_VER_IHL, 8'h00, w_tot_len, id_q, C_FLAGS, P_TTL, P_PROTOCOL,
                         w_csum_field, src_q, dst_q};
    assign w_hdr_byte = w_hdr[(8'd152 - {hidx_q, 3'b000}) +: 8];

`ifdef IP_TX_CSUM_EN
    logic [159:0] w_words;
    logic [15:0]  w_csum;
    logic         w_csum_done;
    logic         w_csum_start;
    logic [15:0]  hdr_csum_q;

    assign w_words      = {C_VER_IHL, 8'h00, w_tot_len, id_q, C_FLAGS, P_TTL, P_PROTOCOL,
                           16'h0000, src_q, dst_q};
    assign w_csum_start = (state_q == ST_CSUM) && (cnt_q == 4'd0);
    assign w_csum_field = hdr_csum_q;

    ip_hdr_csum u_csum (
        .i_clk   (i_clk),
        .i_rst   (i_rst),
        .i_start (w_csum_start),
        .i_words (w_words),
        .o_csum  (w_csum),
        .o_done  (w_csum_done)
    );

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            hdr_csum_q <= '0;
        end else if (w_csum_done) begin
            hdr_csum_q <= w_csum;
        end
    end
`else
    assign w_csum_field = 16'h0000;
`endif

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state_q     <= ST_IDLE;
            cnt_q       <= '0;
            hidx_q      <= '0;
            pcnt_q      <= '0;
            len_q       <= '0;
            id_q        <= '0;
            src_ip_q    <= P_SRC_IP;
            dst_ip_q    <= P_DST_IP;
            src_q       <= '0;
            dst_q       <= '0;
            ended_q     <= 1'b0;
            mac_data_q  <= '0;
            mac_valid_q <= 1'b0;
            mac_last_q  <= 1'b0;
            mac_len_q   <= '0;
            err_len_q   <= 1'b0;
            err_und_q   <= 1'b0;
        end else begin
            err_len_q <= 1'b0;
            err_und_q <= 1'b0;
            if (i_src_ip_valid) src_ip_q <= i_src_ip;
            if (i_dst_ip_valid) dst_ip_q <= i_dst_ip;
            if (mac_last_q)     id_q     <= id_q + 16'd1;

            case (state_q)
                ST_IDLE: begin
                    mac_valid_q <= 1'b0;
                    mac_last_q  <= 1'b0;
                    mac_data_q  <= '0;
                    if (i_send_valid && i_mac_ready) begin
                        len_q   <= i_send_len;
                        src_q   <= src_ip_q;
                        dst_q   <= dst_ip_q;
                        pcnt_q  <= '0;
                        cnt_q   <= '0;
                        ended_q <= 1'b0;
                        if (w_len_bad) begin
                            err_len_q <= 1'b1;
                            state_q   <= ST_DRAIN;
                        end else begin
                            mac_len_q <= i_send_len + 16'(C_HDR_LEN);
`ifdef IP_TX_CSUM_EN
                            state_q   <= ST_CSUM;
`else
                            mac_data_q  <= C_VER_IHL;
                            mac_valid_q <= 1'b1;
                            hidx_q      <= 5'd1;
                            state_q     <= ST_HDR;
`endif
                        end
                    end
                end
`ifdef IP_TX_CSUM_EN
                ST_CSUM: begin
                    cnt_q <= cnt_q + 4'd1;
                    if (cnt_q == 4'(C_CSUM_LAT - 1)) begin
                        mac_data_q  <= C_VER_IHL;
                        mac_valid_q <= 1'b1;
                        hidx_q      <= 5'd1;
                        state_q     <= ST_HDR;
                    end
                end
`endif
                ST_HDR: begin
                    mac_data_q <= w_hdr_byte;
                    hidx_q     <= hidx_q + 5'd1;
                    if (hidx_q == 5'd19) begin
                        state_q <= ST_PAY;
                    end
                end
                // Every PAY cycle emits exactly one byte, so the frame never stalls.
                ST_PAY: begin
                    if (!ended_q && i_send_valid) begin
                        mac_data_q <= i_send_data;
                        if (i_send_last) ended_q <= 1'b1;
                    end else begin
                        mac_data_q <= '0;
                        if (!ended_q) err_und_q <= 1'b1;
                    end
                    pcnt_q <= pcnt_q + 16'd1;
                    if (pcnt_q == len_q - 16'd1) begin
                        mac_last_q <= 1'b1;
                        cnt_q      <= '0;
                        state_q    <= ST_GAP;
                    end
                end
                ST_GAP: begin
                    mac_valid_q <= 1'b0;
                    mac_last_q  <= 1'b0;
                    mac_data_q  <= '0;
                    cnt_q       <= cnt_q + 4'd1;
                    if (cnt_q == P_GAP_CYCLES - 4'd1) begin
                        state_q <= ST_IDLE;
                    end
                end
                ST_DRAIN: begin
                    if (i_send_valid && i_send_last) begin
                        state_q <= ST_IDLE;
                    end
                end
                default: begin
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    assign o_send_ready   = (state_q == ST_DRAIN) || ((state_q == ST_PAY) && !ended_q);
    assign o_mac_type     = C_ETHERTYPE;
    assign o_mac_len      = mac_len_q;
    assign o_mac_data     = mac_data_q;
    assign o_mac_last     = mac_last_q;
    assign o_mac_valid    = mac_valid_q;
    assign o_err_len      = err_len_q;
    assign o_err_underrun = err_und_q;

endmodule
`default_nettype wire

// File: tb/tb_ip_tx.sv
`default_nettype none
// ============================================================================
// Module : tb_ip_tx
// Directed self-checking bench for ip_tx (either IP_TX_CSUM_EN setting).
// Rev    : 1.0
// ============================================================================
module tb_ip_tx;

`ifdef IP_TX_CSUM_EN
    localparam int          L     = 4;
    localparam logic [15:0] CS_A  = 16'hB861;
    localparam logic [15:0] CS_B0 = 16'hB97B;
    localparam logic [15:0] CS_B1 = 16'hB97A;
    localparam int          CSDIF = 1;
`else
    localparam int          L     = 1;
    localparam logic [15:0] CS_A  = 16'h0000;
    localparam logic [15:0] CS_B0 = 16'h0000;
    localparam logic [15:0] CS_B1 = 16'h0000;
    localparam int          CSDIF = 0;
`endif
    localparam logic [31:0] SRC0 = 32'hC0A8_0001;
    localparam logic [31:0] DST0 = 32'hC0A8_0002;
    localparam logic [31:0] DSTA = 32'hC0A8_00C7;

    logic        i_clk = 1'b0;
    logic        i_rst = 1'b1;
    logic [31:0] i_src_ip = '0;
    logic        i_src_ip_valid = 1'b0;
    logic [31:0] i_dst_ip = '0;
    logic        i_dst_ip_valid = 1'b0;
    logic [15:0] i_send_len = '0;
    logic [7:0]  i_send_data = '0;
    logic        i_send_last = 1'b0;
    logic        i_send_valid = 1'b0;
    logic        o_send_ready;
    logic        i_mac_ready = 1'b1;
    logic [15:0] o_mac_type;
    logic [15:0] o_mac_len;
    logic [7:0]  o_mac_data;
    logic        o_mac_last;
    logic        o_mac_valid;
    logic        o_err_len;
    logic        o_err_underrun;

    ip_tx dut (
        .i_clk          (i_clk),
        .i_rst          (i_rst),
        .i_src_ip       (i_src_ip),
        .i_src_ip_valid (i_src_ip_valid),
        .i_dst_ip       (i_dst_ip),
        .i_dst_ip_valid (i_dst_ip_valid),
        .i_send_len     (i_send_len),
        .i_send_data    (i_send_data),
        .i_send_last    (i_send_last),
        .i_send_valid   (i_send_valid),
        .o_send_ready   (o_send_ready),
        .i_mac_ready    (i_mac_ready),
        .o_mac_type     (o_mac_type),
        .o_mac_len      (o_mac_len),
        .o_mac_data     (o_mac_data),
        .o_mac_last     (o_mac_last),
        .o_mac_valid    (o_mac_valid),
        .o_err_len      (o_err_len),
        .o_err_underrun (o_err_underrun)
    );

    always #5 i_clk = ~i_clk;

    int n_checks = 0;
    int n_errors = 0;
    int cyc = 0;
    always @(posedge i_clk) cyc <= cyc + 1;

    // Output monitor: append-only record of every valid frame byte.
    logic [7:0] cap_data [0:4095];
    logic       cap_last [0:4095];
    int fstart [0:31];
    int fcyc   [0:31];
    int fgap   [0:31];
    int cap_n = 0, nfr = 0, nlast = 0, breaks = 0, low_run = 0;
    int n_err_len = 0, n_err_und = 0, rdy_rise = -1;
    logic prev_valid = 1'b0, prev_last = 1'b0, prev_rdy = 1'b0;

    always @(negedge i_clk) begin
        if (o_mac_valid) begin
            if ((!prev_valid || prev_last) && nfr < 32) begin
                fstart[nfr] = cap_n;
                fcyc[nfr]   = cyc;
                fgap[nfr]   = low_run;
                nfr = nfr + 1;
            end
            if (cap_n < 4096) begin
                cap_data[cap_n] = o_mac_data;
                cap_last[cap_n] = o_mac_last;
                cap_n = cap_n + 1;
            end
            if (o_mac_last) nlast = nlast + 1;
            low_run = 0;
        end else begin
            if (prev_valid && !prev_last) breaks = breaks + 1;
            low_run = low_run + 1;
        end
        if (o_send_ready && !prev_rdy) rdy_rise = cyc;
        prev_rdy   = o_send_ready;
        prev_valid = o_mac_valid;
        prev_last  = o_mac_last && o_mac_valid;
        if (o_err_len)      n_err_len = n_err_len + 1;
        if (o_err_underrun) n_err_und = n_err_und + 1;
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks = n_checks + 1;
        if (got !== exp) begin
            n_errors = n_errors + 1;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [7:0] exp_hdr(input int i, input logic [15:0] len,
                                          input logic [15:0] id, input logic [15:0] cs,
                                          input logic [31:0] src, input logic [31:0] dst);
        logic [15:0] tl;
        tl = len + 16'd20;
        case (i)
            0:  return 8'h45;
            1:  return 8'h00;
            2:  return tl[15:8];
            3:  return tl[7:0];
            4:  return id[15:8];
            5:  return id[7:0];
            6:  return 8'h40;
            7:  return 8'h00;
            8:  return 8'h40;
            9:  return 8'h11;
            10: return cs[15:8];
            11: return cs[7:0];
            12: return src[31:24];
            13: return src[23:16];
            14: return src[15:8];
            15: return src[7:0];
            16: return dst[31:24];
            17: return dst[23:16];
            18: return dst[15:8];
            19: return dst[7:0];
            default: return 8'h00;
        endcase
    endfunction

    task automatic check_hdr(input string tag, input int f, input logic [15:0] len,
                             input logic [15:0] id, input logic [15:0] cs,
                             input logic [31:0] src, input logic [31:0] dst);
        for (int i = 0; i < 20; i++) begin
            chk($sformatf("%s_hdr%0d", tag, i), {24'd0, cap_data[fstart[f] + i]},
                {24'd0, exp_hdr(i, len, id, cs, src, dst)});
        end
    endtask

    // Payload pattern is byte k -> k+1; count deviations over a frame.
    task automatic check_pay(input string tag, input int f, input int len);
        int bad = 0;
        for (int k = 0; k < len; k++) begin
            if (cap_data[fstart[f] + 20 + k] !== 8'(k + 1)) bad++;
        end
        chk(tag, bad, 0);
    endtask

    logic abort = 1'b0;

    // Upstream source: presents nbytes (pattern k+1), optionally pausing
    // drop_n cycles once drop_at bytes have been consumed.
    task automatic send(input int len, input int nbytes, input int drop_at, input int drop_n,
                        output int t_acc, output int consumed);
        int k = 0, dropped = 0, guard = 0;
        t_acc = -1;
        while (k < nbytes && guard < 4000 && !abort) begin
            @(negedge i_clk);
            guard++;
            i_send_len = 16'(len);
            if (k == drop_at && dropped < drop_n) begin
                i_send_valid = 1'b0;
                dropped++;
            end else begin
                i_send_valid = 1'b1;
                i_send_data  = 8'(k + 1);
                i_send_last  = (k == nbytes - 1);
            end
            if (i_send_valid && i_mac_ready && t_acc < 0) t_acc = cyc;
            if (i_send_valid && o_send_ready) k++;
        end
        if (guard >= 4000) chk("send_timeout", k, nbytes);
        consumed = k;
    endtask

    task automatic stop_up();
        @(negedge i_clk);
        i_send_valid = 1'b0;
        i_send_last  = 1'b0;
    endtask

    logic [7:0] exp_u [0:7] = '{8'h01, 8'h02, 8'h03, 8'h00, 8'h00, 8'h04, 8'h05, 8'h06};
    int t_acc, cons, r, bc, bf, bl, be, bu, bb;

    initial begin
        repeat (3) @(negedge i_clk);
        chk("rst_valid", o_mac_valid, 0);
        chk("rst_type", o_mac_type, 32'h0800);
        chk("rst_len", o_mac_len, 0);
        chk("rst_ready", o_send_ready, 0);
        chk("rst_last", o_mac_last, 0);
        chk("rst_data", o_mac_data, 0);
        chk("rst_errlen", o_err_len, 0);
        chk("rst_errund", o_err_underrun, 0);
        i_rst = 1'b0;

        // Packet A: len 95 with a reprogrammed destination.
        @(negedge i_clk);
        i_dst_ip = DSTA; i_dst_ip_valid = 1'b1;
        @(negedge i_clk);
        i_dst_ip_valid = 1'b0;
        bc = cap_n; bf = nfr; bl = nlast; bb = breaks;
        send(95, 95, -1, 0, t_acc, cons);
        stop_up();
        repeat (10) @(negedge i_clk);
        chk("A_frames", nfr - bf, 1);
        chk("A_bytes", cap_n - bc, 115);
        chk("A_maclen", o_mac_len, 115);
        chk("A_first_cyc", fcyc[bf], t_acc + L);
        chk("A_ready_cyc", rdy_rise, t_acc + L + 19);
        chk("A_breaks", breaks - bb, 0);
        chk("A_lastpos", cap_last[bc + 114], 1);
        chk("A_nlast", nlast - bl, 1);
        check_hdr("A", bf, 95, 0, CS_A, SRC0, DSTA);
        check_pay("A_pay", bf, 95);

        // Back-to-back 10-byte packets after a reset (default IPs, id 0).
        i_rst = 1'b1;
        @(negedge i_clk);
        i_rst = 1'b0;
        bc = cap_n; bf = nfr;
        send(10, 10, -1, 0, t_acc, cons);
        send(10, 10, -1, 0, t_acc, cons);
        stop_up();
        repeat (30) @(negedge i_clk);
        chk("B_frames", nfr - bf, 2);
        chk("B_gap_ok", fgap[bf + 1] >= 2, 1);
        check_hdr("B0", bf, 10, 0, CS_B0, SRC0, DST0);
        check_hdr("B1", bf + 1, 10, 1, CS_B1, SRC0, DST0);
        chk("B_csdiff", {cap_data[fstart[bf] + 10], cap_data[fstart[bf] + 11]}
                      - {cap_data[fstart[bf + 1] + 10], cap_data[fstart[bf + 1] + 11]}, CSDIF);
        check_pay("B1_pay", bf + 1, 10);

        // Length rejects: drained, no frame, single error pulse each.
        bf = nfr; be = n_err_len;
        send(0, 5, -1, 0, t_acc, cons);
        stop_up();
        repeat (4) @(negedge i_clk);
        chk("R0_drained", cons, 5);
        chk("R0_errlen", n_err_len - be, 1);
        chk("R0_idle_rdy", o_send_ready, 0);
        be = n_err_len;
        send(1481, 5, -1, 0, t_acc, cons);
        stop_up();
        repeat (4) @(negedge i_clk);
        chk("R1_drained", cons, 5);
        chk("R1_errlen", n_err_len - be, 1);
        chk("R_frames", nfr - bf, 0);

        // Underrun: len 8, upstream pauses two cycles after byte 3.
        bc = cap_n; bf = nfr; bu = n_err_und; bb = breaks;
        send(8, 6, 3, 2, t_acc, cons);
        stop_up();
        repeat (10) @(negedge i_clk);
        chk("U_errund", n_err_und - bu, 2);
        chk("U_bytes", cap_n - bc, 28);
        chk("U_breaks", breaks - bb, 0);
        chk("U_lastpos", cap_last[bc + 27], 1);
        chk("U_id", {cap_data[bc + 4], cap_data[bc + 5]}, 2);
        for (int k = 0; k < 8; k++) begin
            chk($sformatf("U_pay%0d", k), cap_data[bc + 20 + k], exp_u[k]);
        end

        // Backpressure: request held off by i_mac_ready.
        bc = cap_n; bf = nfr;
        i_mac_ready = 1'b0;
        fork
            send(4, 4, -1, 0, t_acc, cons);
            begin
                repeat (10) @(negedge i_clk);
                chk("BP_hold", nfr - bf, 0);
                chk("BP_ready", o_send_ready, 0);
                @(posedge i_clk);
                #1 i_mac_ready = 1'b1;
                r = cyc;
            end
        join
        stop_up();
        repeat (10) @(negedge i_clk);
        chk("BP_first_cyc", fcyc[bf], r + L);
        chk("BP_bytes", cap_n - bc, 24);
        chk("BP_id", {cap_data[bc + 4], cap_data[bc + 5]}, 3);

        // Reset in the middle of the payload.
        bc = cap_n;
        fork
            send(20, 20, -1, 0, t_acc, cons);
            begin
                int g = 0;
                while (cap_n - bc < 25 && g < 200) begin
                    @(negedge i_clk);
                    g++;
                end
                chk("RST_reached", cap_n - bc >= 25, 1);
                #1 i_rst = 1'b1;
                #1;
                chk("RST_valid", o_mac_valid, 0);
                chk("RST_ready", o_send_ready, 0);
                chk("RST_maclen", o_mac_len, 0);
                abort = 1'b1;
            end
        join
        stop_up();
        abort = 1'b0;
        repeat (2) @(negedge i_clk);
        i_rst = 1'b0;
        bc = cap_n; bf = nfr;
        send(10, 10, -1, 0, t_acc, cons);
        stop_up();
        repeat (10) @(negedge i_clk);
        chk("PR_bytes", cap_n - bc, 30);
        chk("PR_first_cyc", fcyc[bf], t_acc + L);
        check_hdr("PR", bf, 10, 0, CS_B0, SRC0, DST0);
        check_pay("PR_pay", bf, 10);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1);
    end

endmodule
`default_nettype wire

// File: doc/ip_tx.md
Name: ip_tx

Overview:
IPv4 transmit framer sitting directly upstream of the MAC transmit stage.
- Accepts a UDP datagram byte stream with its declared length.
- Prepends a 20-byte IPv4 header (option-less) with header checksum.
- Streams header and payload as one contiguous-valid frame, with EtherType 0x0800 and frame length, to the MAC stage.

Parameters:
P_SRC_IP, 32'hC0A8_0001, reset value of source IP register
P_DST_IP, 32'hC0A8_0002, reset value of destination IP register
P_TTL, 8'd64, TTL field
P_PROTOCOL, 8'd17, protocol field (UDP)
P_MAX_PAYLOAD, 16'd1480, largest accepted i_send_len
P_GAP_CYCLES, 4'd2, minimum idle cycles of o_mac_valid between frames (≥1)

Ports:
i_clk  in  1  clock
i_rst  in  1  asynchronous, active-high reset
i_src_ip  in  32  new source IP
i_src_ip_valid  in  1  load i_src_ip
i_dst_ip  in  32  new destination IP
i_dst_ip_valid  in  1  load i_dst_ip
i_send_len  in  16  payload byte count; sampled at request accept
i_send_data  in  8  payload byte
i_send_last  in  1  final payload byte
i_send_valid  in  1  upstream byte valid; first rise is the request
o_send_ready  out  1  payload byte consumed when valid & ready
i_mac_ready  in  1  MAC stage can accept a new frame
o_mac_type  out  16  EtherType, constant 16'h0800
o_mac_len  out  16  20 + payload length; stable whole frame
o_mac_data  out  8  frame byte
o_mac_last  out  1  final frame byte
o_mac_valid  out  1  frame byte valid; contiguous within frame
o_err_len  out  1  one-cycle pulse: request rejected
o_err_underrun  out  1  one-cycle pulse: valid dropped before last

Behaviour:
- Reset: all outputs 0 except o_mac_type = 16'h0800; IP registers = parameters; identification = 0; FSM IDLE.
- IP registers load on their valid at any time. Values are snapshot at request accept and used for the whole packet.
- FSM states: IDLE → CSUM (3 cycles) → HDR (20 cycles) → PAY → GAP (P_GAP_CYCLES) → IDLE. Also DRAIN → IDLE.
- Accept: in IDLE, i_send_valid & i_mac_ready at cycle T captures i_send_len. The accepting byte is not consumed (o_send_ready = 0).
- Reject: len == 0 or len > P_MAX_PAYLOAD.
  - o_err_len pulses at T+1; enter DRAIN.
  - o_send_ready = 1 in DRAIN; bytes are discarded until i_send_last is accepted.
  - No MAC output; identification unchanged.
- Header bytes appear on o_mac_data with o_mac_valid = 1 from T+4 to T+23, in this order:
  - 45 00
  - total length = len+20
  - identification
  - 40 00 (DF)
  - P_TTL, P_PROTOCOL
  - checksum
  - src IP, dst IP (MSB first)
- Checksum: one's-complement sum of the ten header words with the checksum word 0. Carries are folded twice; the result is inverted. Computed during CSUM.
- Payload:
  - o_send_ready is high from T+23 while fewer than len bytes have been accepted.
  - An accepted byte appears registered on o_mac_data the next cycle; first payload byte at T+24.
  - o_mac_last is asserted on byte len.
  - Bytes past len are not consumed.
  - If i_send_last arrives early, the remaining bytes are zero-padded.
- Underrun: i_send_valid low while ready during PAY.
  - o_err_underrun pulses.
  - The cycle outputs byte 0x00; remaining bytes continue from upstream or zero if idle.
  - o_mac_valid never drops mid-frame.
- Identification increments (wraps 0xFFFF→0) on o_mac_last of each sent frame.
- i_mac_ready is only checked in IDLE.
- i_rst mid-frame: immediate return to IDLE; outputs cleared asynchronously.

Optional Feature:
IP_TX_CSUM_EN.
- Defined: checksum computed as above; CSUM state present.
- Undefined: checksum field = 16'h0000 and CSUM is skipped. Header spans T+1..T+20; payload starts at T+21; o_send_ready from T+20.

Decomposition:
- Package ip_tx_pkg holds:
  - FSM state enum
  - header length 20
  - EtherType 16'h0800
  - version/IHL byte 8'h45
  - flags word 16'h4000
  - CSUM latency 3
- Sub-module ip_hdr_csum: pipelined 3-cycle one's-complement checksum over ten 16-bit words, with start/done handshake.

Test Plan:
- Checksum and field check (IP_TX_CSUM_EN defined). Stimulus: src C0A80001, dst C0A800C7, len 95, first packet. Expect:
  - header 45 00 00 73 00 00 40 00 40 11 B8 61 C0 A8 00 01 C0 A8 00 C7
  - o_mac_len = 115, o_mac_last on byte 115
  - first header byte at T+4, payload at T+24
- Two back-to-back 10-byte packets: identification goes 0x0000 then 0x0001; o_mac_valid low ≥ 2 cycles between frames; checksums differ by 1 (one's-complement).
- Length rejects:
  - len 0 → o_err_len pulse; 5 upstream bytes drained; no o_mac_valid.
  - len 1481 → same behaviour.
- Underrun: len 8, i_send_valid dropped 2 cycles after byte 3 → o_err_underrun pulse; frame still 28 contiguous valid bytes, with 0x00 in the gap slots.
- Backpressure and reset:
  - i_mac_ready held 0 with a request pending → no output; release → header starts 4 cycles later.
  - i_rst asserted mid-payload → o_mac_valid = 0 immediately; next packet is correct.
- IP_TX_CSUM_EN undefined: len 95 → checksum bytes 00 00, first header byte at T+1.
